// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//   Producer side of the instruction-memory load path for the single-cycle
//   RISC-V core. Takes one field-level instruction per valid/ready handshake,
//   encodes it (lw, sw, R-type, beq), validates it, and writes the 32-bit word
//   to consecutive imem word addresses starting at 0.
//
// Ports
//   clk, reset          clock (rising edge) and asynchronous active-high reset
//   clear               synchronous abort: pointer/count to 0, back to IDLE
//   in_valid/in_ready   field handshake; in_ready is decoded from state
//   in_class            00=lw 01=sw 10=R-type 11=beq
//   in_funct3/funct7b5  R-type function selectors
//   in_rd/rs1/rs2       register fields
//   in_imm              13-bit signed immediate
//   imem_we/addr/wdata  registered one-cycle write port toward imem
//   count               words written since reset/clear
//   full                count has reached DEPTH
//   err                 one-cycle pulse when fields were rejected
module instr_encoder_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_class,
    input  logic [2:0]        in_funct3,
    input  logic              in_funct7b5,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [12:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ENC, WRITE, FULL} state_t;

    state_t state, state_next;

    logic [1:0]        cls_q;
    logic [2:0]        f3_q;
    logic              f7b5_q;
    logic [4:0]        rd_q, rs1_q, rs2_q;
    logic [12:0]       imm_q;
    logic [ADDR_W-1:0] pointer;

    logic [31:0]       enc_word;
    logic              enc_ok;
    logic [ADDR_W:0]   count_inc;

    logic              we_d, err_d, full_d;
    logic [31:0]       wdata_d;
    logic [ADDR_W-1:0] addr_d, pointer_d;
    logic [ADDR_W:0]   count_d;

    assign in_ready  = (state == IDLE) & ~full & ~clear;
    assign count_inc = count + (ADDR_W+1)'(1);

    // Encoder and validity check work on the captured fields, so the result
    // is stable throughout the ENC cycle regardless of what the producer does.
    always_comb begin
        enc_word = 32'h0;
        enc_ok   = 1'b1;
        case (cls_q)
            2'b00: begin
                enc_word = {imm_q[11:0], rs1_q, 3'b010, rd_q, 7'b0000011};
                enc_ok   = (imm_q[12] == imm_q[11]);
            end
            2'b01: begin
                enc_word = {imm_q[11:5], rs2_q, rs1_q, 3'b010, imm_q[4:0], 7'b0100011};
                enc_ok   = (imm_q[12] == imm_q[11]);
            end
            2'b10: begin
                enc_word = {1'b0, f7b5_q, 5'b00000, rs2_q, rs1_q, f3_q, rd_q, 7'b0110011};
                // funct7[5] only has meaning for sub and sra
                enc_ok   = ~f7b5_q | (f3_q == 3'b000) | (f3_q == 3'b101);
            end
            default: begin
                enc_word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, 3'b000,
                            imm_q[4:1], imm_q[11], 7'b1100011};
                enc_ok   = ~imm_q[0];
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic; clear overrides every state including FULL
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (in_valid && in_ready) state_next = ENC;
                ENC:     state_next = enc_ok ? WRITE : IDLE;
                WRITE:   state_next = (count_inc == DEPTH_CNT) ? FULL : IDLE;
                default: state_next = FULL;
            endcase
        end
    end

    // Next values of the registered outputs. The write strobe is raised on the
    // ENC->WRITE edge so it is high exactly during the WRITE cycle.
    always_comb begin
        we_d      = 1'b0;
        err_d     = 1'b0;
        wdata_d   = imem_wdata;
        addr_d    = imem_addr;
        pointer_d = pointer;
        count_d   = count;
        full_d    = full;
        if (clear) begin
            addr_d    = '0;
            pointer_d = '0;
            count_d   = '0;
            full_d    = 1'b0;
        end else begin
            case (state)
                ENC: begin
                    wdata_d = enc_word;
                    if (enc_ok) begin
                        we_d   = 1'b1;
                        addr_d = pointer;
                    end else begin
                        err_d  = 1'b1;
                    end
                end
                WRITE: begin
                    pointer_d = pointer + ADDR_W'(1);
                    count_d   = count_inc;
                    full_d    = (count_inc == DEPTH_CNT);
                end
                default: ;
            endcase
        end
    end

    // Output and pointer registers; the async reset also kills a strobe
    // that is in flight during WRITE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imem_we    <= 1'b0;
            err        <= 1'b0;
            imem_wdata <= 32'h0;
            imem_addr  <= '0;
            pointer    <= '0;
            count      <= '0;
            full       <= 1'b0;
        end else begin
            imem_we    <= we_d;
            err        <= err_d;
            imem_wdata <= wdata_d;
            imem_addr  <= addr_d;
            pointer    <= pointer_d;
            count      <= count_d;
            full       <= full_d;
        end
    end

    // Field capture on a completed handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cls_q  <= 2'b00;
            f3_q   <= 3'b000;
            f7b5_q <= 1'b0;
            rd_q   <= 5'd0;
            rs1_q  <= 5'd0;
            rs2_q  <= 5'd0;
            imm_q  <= 13'd0;
        end else if (in_valid && in_ready) begin
            cls_q  <= in_class;
            f3_q   <= in_funct3;
            f7b5_q <= in_funct7b5;
            rd_q   <= in_rd;
            rs1_q  <= in_rs1;
            rs2_q  <= in_rs2;
            imm_q  <= in_imm;
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader
//   Directed bench for instr_encoder_loader with DEPTH=4. Stimulus pushes the
//   hand-computed write or error event it expects onto a queue; an independent
//   monitor pops an entry whenever the loader strobes imem_we or err and
//   compares kind, address, data and arrival cycle.
module tb_instr_encoder_loader;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    localparam int EXP_NONE  = 0;
    localparam int EXP_WRITE = 1;
    localparam int EXP_ERR   = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              clear = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [1:0]        in_class = '0;
    logic [2:0]        in_funct3 = '0;
    logic              in_funct7b5 = 1'b0;
    logic [4:0]        in_rd = '0;
    logic [4:0]        in_rs1 = '0;
    logic [4:0]        in_rs2 = '0;
    logic [12:0]       in_imm = '0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;

    typedef struct {
        bit          is_err;
        logic [31:0] addr;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   exp_ptr = 0;

    instr_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .count(count), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d",
                     name, actual, expected, cyc);
        end
    endtask

    // Drives one instruction and, once the handshake is certain, records the
    // event expected two cycles after the handshake cycle.
    task automatic applyStimulus(input logic [1:0] cls, input logic [2:0] f3,
                                 input logic f7, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [12:0] imm, input int kind,
                                 input logic [31:0] data);
        exp_t e;
        int   waited = 0;
        @(negedge clk);
        in_class    = cls;
        in_funct3   = f3;
        in_funct7b5 = f7;
        in_rd       = rd;
        in_rs1      = rs1;
        in_rs2      = rs2;
        in_imm      = imm;
        in_valid    = 1'b1;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checkOutput("ready_timeout", {31'b0, in_ready}, 32'd1);
            in_valid = 1'b0;
            return;
        end
        if (kind == EXP_WRITE) begin
            e.is_err = 1'b0;
            e.addr   = exp_ptr;
            e.data   = data;
            e.due    = cyc + 2;
            sb.push_back(e);
            exp_ptr++;
        end else if (kind == EXP_ERR) begin
            e.is_err = 1'b1;
            e.addr   = 32'h0;
            e.data   = 32'h0;
            e.due    = cyc + 2;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Monitor: every strobe must match the oldest expected event
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && (imem_we === 1'b1 || err === 1'b1)) begin
                checkOutput("we_err_exclusive", {31'b0, imem_we & err}, 32'd0);
                if (sb.size() == 0) begin
                    checkOutput("unexpected_strobe", {30'b0, err, imem_we}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("event_kind", {31'b0, err}, {31'b0, e.is_err});
                    if (!e.is_err) begin
                        checkOutput("imem_addr", {30'b0, imem_addr}, e.addr);
                        checkOutput("imem_wdata", imem_wdata, e.data);
                    end
                    checkOutput("event_cycle", cyc, e.due);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_we", {31'b0, imem_we}, 32'd0);
        checkOutput("reset_err", {31'b0, err}, 32'd0);
        checkOutput("reset_full", {31'b0, full}, 32'd0);
        checkOutput("reset_count", {29'b0, count}, 32'd0);
        checkOutput("reset_addr", {30'b0, imem_addr}, 32'd0);
        checkOutput("reset_wdata", imem_wdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // lw x5,8(x2); sw x6,12(x2); sub x1,x2,x3
        applyStimulus(2'b00, 3'd0, 1'b0, 5'd5, 5'd2, 5'd0, 13'd8,  EXP_WRITE, 32'h00812283);
        applyStimulus(2'b01, 3'd0, 1'b0, 5'd0, 5'd2, 5'd6, 13'd12, EXP_WRITE, 32'h00612623);
        applyStimulus(2'b10, 3'd0, 1'b1, 5'd1, 5'd2, 5'd3, 13'd0,  EXP_WRITE, 32'h403100B3);
        repeat (4) @(negedge clk);
        checkOutput("count_after_3", {29'b0, count}, 32'd3);

        // Rejected: beq odd offset, lw imm 3000, R-type funct7b5 with funct3=001
        applyStimulus(2'b11, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 13'd3,    EXP_ERR, 32'h0);
        applyStimulus(2'b00, 3'd0, 1'b0, 5'd5, 5'd2, 5'd0, 13'd3000, EXP_ERR, 32'h0);
        applyStimulus(2'b10, 3'd1, 1'b1, 5'd1, 5'd2, 5'd3, 13'd0,    EXP_ERR, 32'h0);
        repeat (4) @(negedge clk);
        checkOutput("count_after_err", {29'b0, count}, 32'd3);
        checkOutput("full_after_err", {31'b0, full}, 32'd0);

        // add x1,x2,x3 fills the last word
        applyStimulus(2'b10, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 13'd0, EXP_WRITE, 32'h003100B3);
        repeat (4) @(negedge clk);
        checkOutput("full_set", {31'b0, full}, 32'd1);
        checkOutput("count_full", {29'b0, count}, 32'd4);
        checkOutput("ready_when_full", {31'b0, in_ready}, 32'd0);

        // Offered fields while FULL must be ignored
        in_class = 2'b00; in_rd = 5'd5; in_rs1 = 5'd2; in_imm = 13'd8;
        in_valid = 1'b1;
        repeat (6) @(negedge clk);
        in_valid = 1'b0;
        checkOutput("count_hold_full", {29'b0, count}, 32'd4);
        checkOutput("full_hold", {31'b0, full}, 32'd1);

        // clear leaves FULL
        clear = 1'b1;
        #1 checkOutput("ready_during_clear", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        clear = 1'b0;
        exp_ptr = 0;
        #1;
        checkOutput("count_after_clear", {29'b0, count}, 32'd0);
        checkOutput("full_after_clear", {31'b0, full}, 32'd0);
        checkOutput("ready_after_clear", {31'b0, in_ready}, 32'd1);

        // beq x1,x2,-4 lands at address 0 again
        applyStimulus(2'b11, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 13'h1FFC, EXP_WRITE, 32'hFE208EE3);
        repeat (4) @(negedge clk);
        checkOutput("count_after_beq", {29'b0, count}, 32'd1);

        // Simultaneous clear and valid: no accept, count back to 0
        clear = 1'b1; in_valid = 1'b1;
        #1 checkOutput("ready_clear_valid", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        exp_ptr = 0;
        repeat (4) @(negedge clk);
        checkOutput("count_clear_valid", {29'b0, count}, 32'd0);

        // clear during ENC aborts the write
        applyStimulus(2'b00, 3'd0, 1'b0, 5'd5, 5'd2, 5'd0, 13'd8, EXP_NONE, 32'h0);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("count_clear_enc", {29'b0, count}, 32'd0);
        checkOutput("ready_clear_enc", {31'b0, in_ready}, 32'd1);

        // One good write, then reset asserted during the next WRITE cycle
        applyStimulus(2'b00, 3'd0, 1'b0, 5'd5, 5'd2, 5'd0, 13'd8, EXP_WRITE, 32'h00812283);
        repeat (4) @(negedge clk);
        checkOutput("count_before_reset", {29'b0, count}, 32'd1);
        applyStimulus(2'b01, 3'd0, 1'b0, 5'd0, 5'd2, 5'd6, 13'd12, EXP_NONE, 32'h0);
        @(posedge clk);
        #2 checkOutput("we_in_write", {31'b0, imem_we}, 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("we_async_drop", {31'b0, imem_we}, 32'd0);
        checkOutput("count_async_reset", {29'b0, count}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_ptr = 0;
        repeat (4) @(negedge clk);
        checkOutput("count_after_reset", {29'b0, count}, 32'd0);
        checkOutput("scoreboard_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
